ysyx_23060072_redirect_ctrl: RTL
================================

Name: ysyx_23060072_redirect_ctrl

Overview:
- Sequences control-flow redirects produced by the EX-stage ALU (taken branch, JAL, JALR, FENCE.I) into the fetch unit.
- Captures the jump target, drives a valid/ready redirect handshake to IF, and holds a flush of younger instructions for a programmable number of cycles.
- For FENCE.I, first waits for the LSU to drain, then runs an I-cache flush handshake before redirecting.
- Sits between the EX stage and the IF/ID/ID-EX pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high after the redirect handshake completes, counting the handshake cycle; legal range 1..15.
- CNT_W, 16, width of the saturating redirect event counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_i  in  1  instruction in EX is valid this cycle
- ex_jump_flag_i  in  1  ALU jump flag (taken branch/JAL/JALR/FENCE.I)
- ex_jump_pc_i  in  32  ALU jump target (pc+4 for FENCE.I)
- ex_fence_i_i  in  1  EX instruction is FENCE.I
- ifu_ready_i  in  1  IF accepts redirect this cycle
- lsu_idle_i  in  1  no outstanding loads/stores
- icache_flush_ack_i  in  1  I-cache flush complete (single-cycle pulse)
- redirect_valid_o  out  1  redirect request to IF
- redirect_pc_o  out  32  redirect target
- flush_o  out  1  kill younger instructions in IF/ID and ID/EX
- ex_stall_o  out  1  freeze IF/ID/EX front end
- icache_flush_req_o  out  1  I-cache flush request
- redirect_cnt_o  out  CNT_W  number of completed redirects, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including redirect_pc_o, the hold counter and redirect_cnt_o. Reset asserted mid-operation aborts immediately; no redirect or flush request persists past reset.
- States: IDLE, FDRAIN, FFLUSH, REDIR, HOLD. All outputs are registered or decoded purely from state.
- IDLE:
  - An event is ex_valid_i & ex_jump_flag_i. On an event in cycle T, latch ex_jump_pc_i into redirect_pc_o.
  - If ex_fence_i_i=1, go to FDRAIN. Otherwise go to REDIR at T+1.
  - ex_fence_i_i without ex_jump_flag_i is not an event.
- FDRAIN: ex_stall_o=1. Stay until lsu_idle_i=1, then go to FFLUSH.
- FFLUSH:
  - ex_stall_o=1 and icache_flush_req_o=1, held until icache_flush_ack_i.
  - On the ack cycle, go to REDIR. icache_flush_req_o drops in the next cycle.
  - An ack arriving in any other state is ignored.
- REDIR:
  - redirect_valid_o=1, flush_o=1, ex_stall_o=1. redirect_pc_o stays stable until the transfer.
  - Transfer occurs when ifu_ready_i=1. On transfer, redirect_cnt_o increments (saturating at all-ones).
  - After transfer: if FLUSH_CYCLES=1, go to IDLE; otherwise go to HOLD and load the hold counter with FLUSH_CYCLES-2.
- HOLD: flush_o=1, ex_stall_o=1, redirect_valid_o=0. Decrement the counter each cycle; at 0 go to IDLE.
- Net flush length: flush_o is high for (REDIR cycles) + FLUSH_CYCLES-1 cycles.
- Events arriving in any state other than IDLE are ignored; ex_stall_o guarantees none should arrive.
- Redirect latency for a non-fence event: the request is visible one cycle after the event, and IDLE is re-entered FLUSH_CYCLES cycles after the transfer cycle.
- redirect_pc_o is never modified outside the IDLE capture. It holds its last value while idle.

Decomposition:
- Shared package/define file holds the state encodings (3-bit) and the FLUSH_CYCLES legal range constants, alongside the existing ALU op defines.
- No sub-module is needed. The saturating counter is inline. Optionally factor out ysyx_23060072_sat_cnt if another performance counter reuses it.

Test Plan:
- Branch event, ex_jump_pc_i=0x8000_0040, ifu_ready_i=1 → redirect_valid_o=1 and redirect_pc_o=0x8000_0040 at T+1; flush_o high for cycles T+1..T+2 (FLUSH_CYCLES=2); IDLE at T+3; redirect_cnt_o=1.
- Same event with ifu_ready_i low for 3 cycles → redirect_valid_o, flush_o and the PC are held stable for 4 cycles; a single transfer occurs; the counter increments once.
- FENCE.I event, pc=0x8000_0104, lsu_idle_i low for 5 cycles, ack 2 cycles after the request → stall held throughout; icache_flush_req_o only after lsu_idle_i; redirect to 0x8000_0104 after the ack; no early redirect_valid_o.
- Event injected while in HOLD with a different PC → ignored; redirect_pc_o unchanged; counter unchanged.
- rst_n pulsed low while in FFLUSH → all outputs 0 asynchronously; IDLE after release; a stray icache_flush_ack_i afterwards has no effect.
- redirect_cnt_o preset near saturation (CNT_W=4, after 15 redirects) → a 16th redirect leaves it at 0xF; FLUSH_CYCLES=1 build → flush_o exactly 1 cycle when ifu_ready_i=1.

Source files
------------

// File: rtl/ysyx_23060072_redirect_ctrl_pkg.sv
// Shared types for the EX->IF redirect controller.
// State encodings and flush-length limits.
package ysyx_23060072_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FDRAIN = 3'd1,
        S_FFLUSH = 3'd2,
        S_REDIR  = 3'd3,
        S_HOLD   = 3'd4
    } redir_state_t;

    localparam int FLUSH_CYCLES_MIN = 1;
    localparam int FLUSH_CYCLES_MAX = 15;
    localparam int HOLD_W           = 4;

endpackage

// File: rtl/ysyx_23060072_redirect_ctrl_if.sv
// Bundle between EX, IF, LSU and I-cache for redirects.
// master = redirect controller, slave = surrounding core.
interface ysyx_23060072_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ex_valid_i;
    logic             ex_jump_flag_i;
    logic [31:0]      ex_jump_pc_i;
    logic             ex_fence_i_i;
    logic             ifu_ready_i;
    logic             lsu_idle_i;
    logic             icache_flush_ack_i;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic             ex_stall_o;
    logic             icache_flush_req_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        input  ex_valid_i,
        input  ex_jump_flag_i,
        input  ex_jump_pc_i,
        input  ex_fence_i_i,
        input  ifu_ready_i,
        input  lsu_idle_i,
        input  icache_flush_ack_i,
        output redirect_valid_o,
        output redirect_pc_o,
        output flush_o,
        output ex_stall_o,
        output icache_flush_req_o,
        output redirect_cnt_o
    );

    modport slave (
        output ex_valid_i,
        output ex_jump_flag_i,
        output ex_jump_pc_i,
        output ex_fence_i_i,
        output ifu_ready_i,
        output lsu_idle_i,
        output icache_flush_ack_i,
        input  redirect_valid_o,
        input  redirect_pc_o,
        input  flush_o,
        input  ex_stall_o,
        input  icache_flush_req_o,
        input  redirect_cnt_o
    );

endinterface

// File: rtl/ysyx_23060072_redirect_ctrl.sv
// Sequences EX-stage jumps and FENCE.I into IF redirects.
// Holds the front end flushed/stalled until the redirect settles.
module ysyx_23060072_redirect_ctrl
    import ysyx_23060072_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_23060072_redirect_ctrl_if.master bus
);

    localparam logic [HOLD_W-1:0] HOLD_INIT =
        (FLUSH_CYCLES > 1) ? HOLD_W'(FLUSH_CYCLES - 2) : '0;

    redir_state_t      state;
    logic [31:0]       pc_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              event_hit;

    assign event_hit = bus.ex_valid_i & bus.ex_jump_flag_i;

    // Control FSM: capture target, drain/flush for FENCE.I, redirect, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc_q   <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (event_hit) begin
                        pc_q  <= bus.ex_jump_pc_i;
                        state <= bus.ex_fence_i_i ? S_FDRAIN : S_REDIR;
                    end
                end
                S_FDRAIN: begin
                    if (bus.lsu_idle_i) state <= S_FFLUSH;
                end
                S_FFLUSH: begin
                    if (bus.icache_flush_ack_i) state <= S_REDIR;
                end
                S_REDIR: begin
                    if (bus.ifu_ready_i) begin
                        cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        if (FLUSH_CYCLES == 1) begin
                            state <= S_IDLE;
                        end else begin
                            state  <= S_HOLD;
                            hold_q <= HOLD_INIT;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) state <= S_IDLE;
                    else              hold_q <= hold_q - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        bus.redirect_valid_o   = (state == S_REDIR);
        bus.flush_o            = (state == S_REDIR) | (state == S_HOLD);
        bus.ex_stall_o         = (state != S_IDLE);
        bus.icache_flush_req_o = (state == S_FFLUSH);
        bus.redirect_pc_o      = pc_q;
        bus.redirect_cnt_o     = cnt_q;
    end

endmodule
